// File: rtl/bp_pkg.sv
// Shared branch-predictor package: table geometry, counter type and the
// saturating-counter update rule. Reused by the LHT, global and choice tables.
package bp_pkg;

  localparam int HIST_BITS = 10;
  localparam int CTR_BITS  = 3;
  localparam int TABLE_DEPTH = 1 << HIST_BITS;

  typedef logic [HIST_BITS-1:0] hist_t;
  typedef logic [CTR_BITS-1:0]  ctr_t;

  // Weakly not-taken: MSB clear, one step below the taken threshold.
  localparam ctr_t CTR_INIT = 3'b011;
  localparam ctr_t CTR_MAX  = {CTR_BITS{1'b1}};
  localparam ctr_t CTR_MIN  = '0;

  // Next counter value after training with one outcome; never wraps.
  function automatic ctr_t sat_ctr_next(ctr_t c, logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_MAX) r = c + ctr_t'(1);
    end else begin
      if (c != CTR_MIN) r = c - ctr_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/local_pred_table.sv
// Local prediction table: 2^HIST_BITS saturating counters indexed by the
// per-branch local history. One registered lookup and one update per cycle,
// with write-first bypass when both hit the same entry.
// Optional misprediction statistics are enabled with macro LPT_STATS_EN.
module local_pred_table
  import bp_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lookup_valid,
  input  logic [HIST_BITS-1:0] lookup_hist,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [CTR_BITS-1:0]  pred_ctr,
  input  logic                 update_valid,
  input  logic [HIST_BITS-1:0] update_hist,
  input  logic                 update_taken
`ifdef LPT_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [15:0]          mispred_cnt
`endif
);

  ctr_t  ctr_mem_q [TABLE_DEPTH];

  ctr_t  upd_old;
  ctr_t  upd_new;
  ctr_t  rd_val;
  logic  same_idx;

  logic  pred_valid_d, pred_valid_q;
  ctr_t  pred_ctr_d,   pred_ctr_q;

  // Update datapath: read the trained entry and compute its saturated successor.
  always_comb begin
    upd_old = ctr_mem_q[update_hist];
    upd_new = sat_ctr_next(upd_old, update_taken);
  end

  // Lookup datapath: write-first bypass when the update targets the same entry.
  always_comb begin
    same_idx = update_valid && (update_hist == lookup_hist);
    rd_val   = same_idx ? upd_new : ctr_mem_q[lookup_hist];
    pred_valid_d = lookup_valid;
    pred_ctr_d   = lookup_valid ? rd_val : pred_ctr_q;
  end

  // Counter array: every entry returns to weakly not-taken on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        ctr_mem_q[i] <= CTR_INIT;
      end
    end else if (update_valid) begin
      ctr_mem_q[update_hist] <= upd_new;
    end
  end

  // Prediction register: valid follows the request, data holds when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pred_valid_q <= 1'b0;
      pred_ctr_q   <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_ctr_q   <= pred_ctr_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_ctr   = pred_ctr_q;
  assign pred_taken = pred_ctr_q[CTR_BITS-1];

`ifdef LPT_STATS_EN
  logic [15:0] mispred_cnt_d, mispred_cnt_q;

  // Misprediction counter: pre-update direction vs outcome, clear has priority.
  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (stats_clr) begin
      mispred_cnt_d = '0;
    end else if (update_valid && (upd_old[CTR_BITS-1] != update_taken)
                 && (mispred_cnt_q != 16'hFFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 16'd1;
    end
  end

  // Statistics register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mispred_cnt_q <= '0;
    end else begin
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispred_cnt = mispred_cnt_q;
`endif

  // Request fields must be known whenever their valid is asserted.
  a_lookup_known: assert property (@(posedge clock) disable iff (!reset)
    lookup_valid |-> !$isunknown(lookup_hist));
  a_update_known: assert property (@(posedge clock) disable iff (!reset)
    update_valid |-> !$isunknown({update_hist, update_taken}));

endmodule

// File: doc/local_pred_table.md
Name: local_pred_table

Overview:
- Local prediction table (LPT) stage of the tournament branch predictor. Sits directly downstream of the local history table.
- Indexed by the 10-bit per-branch local history that the LHT produces. Holds 2^HIST_BITS saturating counters.
- Returns a registered taken/not-taken prediction one cycle after lookup.
- Trains the indexed counter on branch resolution.

Parameters:
- HIST_BITS, 10, width of local history index; table depth = 2^HIST_BITS
- CTR_BITS, 3, width of each saturating counter
- CTR_INIT, 3'b011, reset value of every counter (weakly not-taken)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- lookup_valid  input  1  lookup request this cycle
- lookup_hist  input  HIST_BITS  local history from LHT, used as table index
- pred_valid  output  1  prediction valid (registered)
- pred_taken  output  1  predicted direction = MSB of counter
- pred_ctr  output  CTR_BITS  full counter value read
- update_valid  input  1  branch resolved, train counter
- update_hist  input  HIST_BITS  history index captured at lookup time
- update_taken  input  1  actual branch outcome

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - every counter = CTR_INIT
  - pred_valid = 0, pred_taken = 0, pred_ctr = 0
  - any in-flight lookup is discarded
- Lookup latency is 1 cycle.
  - lookup_valid=1 at edge N: at edge N+1, pred_valid=1, pred_ctr=counter[lookup_hist], pred_taken=pred_ctr[CTR_BITS-1].
  - lookup_valid=0: pred_valid=0 next cycle; pred_taken/pred_ctr hold their last values.
- Update: update_valid=1 at an edge writes counter[update_hist] at that edge.
  - update_taken=1: counter+1, saturating at 2^CTR_BITS-1 (7).
  - update_taken=0: counter-1, saturating at 0.
  - Arithmetic stays within CTR_BITS; no wrap, ever.
- Simultaneous lookup and update:
  - Same index: write-first bypass. Prediction reflects the post-update counter.
  - Different index: lookup and update are fully independent.
- Back-to-back updates to the same index on consecutive cycles each apply exactly once, cumulatively.
- Inputs may be X while their valid is 0. When update_valid=1 or lookup_valid=1, X on the associated fields is a bench error and is flagged by assertion.
- No stall or backpressure. The table accepts one lookup and one update every cycle.

Optional Feature:
- Macro LPT_STATS_EN.
- Defined:
  - Adds output mispred_cnt (16 bits) and input stats_clr (1 bit).
  - On each update, compare the pre-update counter MSB with update_taken. A mismatch increments mispred_cnt, saturating at 16'hFFFF.
  - stats_clr=1 zeroes mispred_cnt next edge; clear wins over a simultaneous increment.
  - reset=0 zeroes mispred_cnt.
- Undefined: those ports and logic are absent. Core behaviour is identical.

Decomposition:
- Shared package bp_pkg holds:
  - HIST_BITS and CTR_BITS constants
  - typedefs hist_t (logic [HIST_BITS-1:0]) and ctr_t (logic [CTR_BITS-1:0])
  - CTR_INIT
  - function sat_ctr_next(ctr_t c, logic taken), returning the saturated next value
- The LHT and the global/choice tables reuse the same package.
- No sub-module: the counter array, read register and bypass mux live in local_pred_table itself.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then lookup hist=10'h000, 10'h3FF, 10'h155 -> pred_ctr=3'b011, pred_taken=0 each; pred_valid=0 during reset.
- Saturate up: 6 updates taken at hist=10'h0A5, then lookup -> pred_ctr=7, pred_taken=1; 2 more taken updates -> still 7.
- Saturate down: 5 updates not-taken at hist=10'h2C3, then lookup -> pred_ctr=0, pred_taken=0; a further not-taken update -> still 0.
- Bypass: counter[10'h011]=3; same cycle lookup 10'h011 + update taken 10'h011 -> next cycle pred_ctr=4, pred_taken=1. Repeat with update to 10'h012 -> pred_ctr=3.
- Mid-operation reset: train 10'h100 to 7, issue lookup, assert reset=0 asynchronously mid-cycle -> pred_valid drops immediately; after release, lookup 10'h100 gives 3.
- LPT_STATS_EN: counter at 3, 4 taken updates on one index -> mispred_cnt=1 (only the first update mispredicts); stats_clr pulse -> 0.
